// File: rtl/bytebeat_voice_scheduler.sv
// Sample-rate scheduler and mixer for the bytebeat generator bank: polls each enabled
// voice once per sample tick, holds the captured samples and emits their averaged mix.
module bytebeat_voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 8,
  parameter int CLK_DIV    = 1250,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_VOICES-1:0]          voice_mask,
  input  logic                           status_clr,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] gen_data,
  input  logic [NUM_VOICES-1:0]          gen_vld,
  output logic [NUM_VOICES-1:0]          gen_rdy,
  output logic [SAMPLE_W-1:0]            mix_sample,
  output logic                           mix_strobe,
  output logic                           busy,
  output logic [NUM_VOICES-1:0]          stall_err,
  output logic                           tick_overrun
);

  localparam int LOG_V  = $clog2(NUM_VOICES);
  localparam int SUM_W  = SAMPLE_W + LOG_V;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [LOG_V-1:0]  LAST_IDX = LOG_V'(NUM_VOICES - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MIX     = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [LOG_V-1:0]    idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [NUM_VOICES-1:0] mask_q;
  logic [SAMPLE_W-1:0] held [NUM_VOICES];
  logic                sel_en, handshake, timed_out, advance;
  logic [SUM_W-1:0]    sum;

  assign tick      = (div_cnt == DIV_MAX);
  assign sel_en    = (state == COLLECT) && mask_q[idx];
  assign handshake = sel_en && gen_vld[idx];
  assign timed_out = sel_en && !gen_vld[idx] && (wait_cnt == WAIT_MAX);
  assign advance   = (state == COLLECT) && (!mask_q[idx] || handshake || timed_out);
  assign busy      = (state != IDLE);

  // Free-running sample divider; keeps counting through every FSM state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = COLLECT;
      COLLECT: if (advance && (idx == LAST_IDX)) state_nx = MIX;
      MIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready is decoded straight from state so it drops in the cycle reset takes effect.
  always_comb begin
    // NOTE: default assigned first so no path leaves gen_rdy unassigned (no latch).
    gen_rdy = '0;
    if (sel_en) gen_rdy[idx] = 1'b1;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + SUM_W'(held[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      wait_cnt     <= '0;
      mask_q       <= '0;
      mix_sample   <= '0;
      mix_strobe   <= 1'b0;
      stall_err    <= '0;
      tick_overrun <= 1'b0;
      // NOTE: held is a small flop bank, so it is cleared on reset like any register.
      for (int i = 0; i < NUM_VOICES; i++) held[i] <= '0;
    end else begin
      mix_strobe <= 1'b0;

      if (state == IDLE && tick) begin
        mask_q   <= voice_mask;
        idx      <= '0;
        wait_cnt <= '0;
      end

      if (state == COLLECT) begin
        if (!mask_q[idx])   held[idx] <= '0;
        else if (handshake) held[idx] <= gen_data[idx*SAMPLE_W +: SAMPLE_W];

        if (advance) begin
          wait_cnt <= '0;
          if (idx != LAST_IDX) idx <= idx + LOG_V'(1);
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end

      if (state == MIX) begin
        mix_sample <= SAMPLE_W'(sum >> LOG_V);
        mix_strobe <= 1'b1;
      end

      // Clear first so a same-cycle set event overrides it.
      if (status_clr) stall_err <= '0;
      if (timed_out)  stall_err[idx] <= 1'b1;

      if (status_clr)           tick_overrun <= 1'b0;
      if (tick && state != IDLE) tick_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bytebeat_voice_scheduler.sv
// Self-checking bench for bytebeat_voice_scheduler: directed scenarios plus random frames
// checked against a frame-level model (per-voice duration, held samples, sticky stalls).
module tb_bytebeat_voice_scheduler;

  localparam int NV  = 8;
  localparam int SW  = 8;
  localparam int CD  = 32;
  localparam int TO  = 4;
  localparam int CD2 = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NV-1:0]   voice_mask = '0;
  logic            status_clr = 1'b0;
  logic [NV*SW-1:0] gen_data = '0;
  logic [NV-1:0]   gen_vld = '0;
  logic [NV-1:0]   gen_rdy;
  logic [SW-1:0]   mix_sample;
  logic            mix_strobe;
  logic            busy;
  logic [NV-1:0]   stall_err;
  logic            tick_overrun;

  logic            reset2 = 1'b1;
  logic [NV-1:0]   voice_mask2 = '0;
  logic            status_clr2 = 1'b0;
  logic [NV*SW-1:0] gen_data2 = '0;
  logic [NV-1:0]   gen_vld2 = '0;
  logic [NV-1:0]   gen_rdy2;
  logic [SW-1:0]   mix_sample2;
  logic            mix_strobe2;
  logic            busy2;
  logic [NV-1:0]   stall_err2;
  logic            tick_overrun2;

  bytebeat_voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .CLK_DIV(CD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .voice_mask(voice_mask), .status_clr(status_clr),
    .gen_data(gen_data), .gen_vld(gen_vld), .gen_rdy(gen_rdy), .mix_sample(mix_sample),
    .mix_strobe(mix_strobe), .busy(busy), .stall_err(stall_err), .tick_overrun(tick_overrun)
  );

  bytebeat_voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .CLK_DIV(CD2), .TIMEOUT(TO)) dut2 (
    .clk(clk), .reset(reset2), .voice_mask(voice_mask2), .status_clr(status_clr2),
    .gen_data(gen_data2), .gen_vld(gen_vld2), .gen_rdy(gen_rdy2), .mix_sample(mix_sample2),
    .mix_strobe(mix_strobe2), .busy(busy2), .stall_err(stall_err2), .tick_overrun(tick_overrun2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_strobe = -1;

  logic [SW-1:0] m_held [NV];
  logic [NV-1:0] m_stall;
  logic [NV-1:0] f_mask;
  logic [SW-1:0] f_data [NV];
  int            f_dly  [NV];
  int            rcnt   [NV];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_held[i] = '0;
    m_stall = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  // A selected voice raises valid once its ready has been up for f_dly cycles;
  // unselected voices show random valid, which the scheduler must ignore.
  task automatic drive_vld();
    for (int i = 0; i < NV; i++) begin
      if (gen_rdy[i]) begin
        gen_vld[i] = (rcnt[i] >= f_dly[i]);
        rcnt[i]++;
      end else begin
        gen_vld[i] = 1'($urandom);
      end
    end
  endtask

  task automatic run_frame(input bit walk, input string tag);
    int stray = 0;
    int dur = 0;
    int got = -1;
    int s = 0;
    gen_vld = '0;
    for (int g = 0; g < 2*CD && (cyc % CD) != CD-1; g++) begin
      step();
      if (mix_strobe) stray++;
    end
    check($sformatf("%s_stray_strobe", tag), stray, 0);

    voice_mask = f_mask;
    for (int i = 0; i < NV; i++) begin
      gen_data[i*SW +: SW] = f_data[i];
      rcnt[i] = 0;
    end
    drive_vld();

    for (int i = 0; i < NV; i++) begin
      if (!f_mask[i]) begin
        m_held[i] = '0;
        dur += 1;
      end else if (f_dly[i] < TO) begin
        m_held[i] = f_data[i];
        dur += f_dly[i] + 1;
      end else begin
        m_stall[i] = 1'b1;
        dur += TO;
      end
      s += int'(m_held[i]);
    end

    for (int k = 1; k <= 60 && got < 0; k++) begin
      step();
      if (k == 1) voice_mask = 8'($urandom);
      drive_vld();
      if (walk && k <= NV) check($sformatf("%s_rdy_walk%0d", tag, k), gen_rdy, 32'(1 << (k-1)));
      if (mix_strobe) begin
        got = k;
        last_strobe = cyc;
      end
    end
    check($sformatf("%s_latency", tag), got, dur + 2);
    check($sformatf("%s_mix", tag), mix_sample, s >> 3);
    check($sformatf("%s_stall", tag), stall_err, m_stall);
    step();
    check($sformatf("%s_strobe_pulse", tag), mix_strobe, 0);
  endtask

  task automatic set_frame(input logic [NV-1:0] mask, input logic [SW-1:0] d, input int dly);
    f_mask = mask;
    for (int i = 0; i < NV; i++) begin
      f_data[i] = d;
      f_dly[i]  = dly;
    end
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    m_stall = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Reset state and first tick timing.
    do_reset(3);
    check("rst_mix_sample", mix_sample, 0);
    check("rst_mix_strobe", mix_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_tick_overrun", tick_overrun, 0);
    check("rst_gen_rdy", gen_rdy, 0);
    set_frame(8'h00, 8'h00, 0);
    run_frame(1'b0, "first");
    check("first_strobe_cycle", last_strobe, 41);

    // Voice 3 never valid: held 0 contributes, sticky stall on bit 3.
    set_frame(8'hFF, 8'd80, 0);
    f_dly[3] = 9;
    run_frame(1'b0, "timeout");

    // All valid, ramp data, walking ready; stall bit still sticky.
    set_frame(8'hFF, 8'h00, 0);
    for (int i = 0; i < NV; i++) f_data[i] = 8'(16 * i);
    run_frame(1'b1, "ramp");
    pulse_clr();
    check("stall_cleared", stall_err, 0);

    // Full scale, then single voice.
    set_frame(8'hFF, 8'hFF, 0);
    run_frame(1'b0, "fullscale");
    f_mask = 8'h01;
    run_frame(1'b0, "single");

    // Voice 2 valid 3 cycles after ready.
    set_frame(8'hFF, 8'h00, 0);
    for (int i = 0; i < NV; i++) f_data[i] = 8'(16 * i);
    f_dly[2] = 3;
    run_frame(1'b0, "late");

    // Random frames against the model.
    for (int r = 0; r < 20; r++) begin
      int a, b;
      f_mask = 8'($urandom);
      for (int i = 0; i < NV; i++) begin
        f_data[i] = 8'($urandom);
        f_dly[i]  = $urandom_range(0, 2);
      end
      a = $urandom_range(0, NV-1);
      b = $urandom_range(0, NV-1);
      f_dly[a] = $urandom_range(0, 6);
      f_dly[b] = $urandom_range(0, 6);
      run_frame(1'b0, $sformatf("rand%0d", r));
      if (r % 5 == 4) pulse_clr();
    end
    check("no_overrun", tick_overrun, 0);

    // Reset in the middle of COLLECT at voice 4.
    set_frame(8'hFF, 8'h60, 0);
    run_frame(1'b0, "premid");
    gen_vld = '0;
    for (int g = 0; g < 2*CD && (cyc % CD) != CD-1; g++) step();
    voice_mask = 8'hFF;
    for (int k = 0; k < 40 && gen_rdy != 8'h10; k++) begin
      step();
      gen_vld = '0;
    end
    check("midrst_reach_idx4", gen_rdy, 8'h10);
    reset = 1'b1;
    step();
    check("midrst_gen_rdy", gen_rdy, 0);
    check("midrst_strobe", mix_strobe, 0);
    check("midrst_mix_sample", mix_sample, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    cyc = 0;
    model_reset();
    set_frame(8'h0F, 8'h33, 9);
    run_frame(1'b0, "postrst");

    // Divider shorter than a frame: second instance overruns.
    voice_mask2 = 8'hFF;
    gen_vld2 = '0;
    reset2 = 1'b0;
    repeat (40) step();
    check("ovr_tick_overrun", tick_overrun2, 1);
    check("ovr_stall_err", stall_err2, 8'hFF);
    status_clr2 = 1'b1;
    step();
    status_clr2 = 1'b0;
    check("ovr_clr_overrun", tick_overrun2, 0);
    check("ovr_clr_stall", stall_err2, 0);
    check("ovr_strobe", mix_strobe2, 1);
    check("ovr_mix", mix_sample2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
